// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared forward-select codes, shadow-entry layout and hazard FSM states.
// Types and constants only; adds no latency and has no flow control of its own.
package fwd_hazard_ctrl_pkg;

  localparam int SH_REG_W = 5;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_DMEM  = 2'b11;

  typedef struct packed {
    logic                vld;
    logic [SH_REG_W-1:0] rs1;
    logic [SH_REG_W-1:0] rs2;
    logic                use1;
    logic                use2;
    logic [SH_REG_W-1:0] rd;
    logic                regwrite;
    logic                isload;
    logic                isjump;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward priority: MEM producer beats WB producer; x0 and unused operands never forward.
// Purely combinational, zero latency; no backpressure. Code 11 for a load in MEM exists only with LOAD_FWD_EN.
module fwd_select
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_use,
  input  logic             i_ex_vld,
  input  logic             i_mem_vld,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_isload,
  input  logic             i_mem_isjump,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_wb_vld,
  input  logic             i_wb_regwrite,
  input  logic [REG_W-1:0] i_wb_rd,
  output logic [1:0]       o_fwd,
  output logic             o_isjump
);

  logic w_live;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_live    = i_ex_vld & i_use & (i_rs != '0);
  assign w_mem_hit = i_mem_vld & i_mem_regwrite & (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_vld & i_wb_regwrite & (i_wb_rd == i_rs);

  always_comb begin
    o_fwd    = FWD_NONE;
    o_isjump = 1'b0;
    if (w_live) begin
      if (w_mem_hit) begin
`ifdef LOAD_FWD_EN
        if (i_mem_isload) begin
          o_fwd = FWD_DMEM;
        end else begin
          o_fwd    = FWD_EXMEM;
          o_isjump = i_mem_isjump;
        end
`else
        // Without the D_MEM path a load never reaches EX's consumer from MEM; the stall guarantees it.
        o_fwd    = FWD_EXMEM;
        o_isjump = i_mem_isjump;
`endif
      end else if (w_wb_hit) begin
        o_fwd = FWD_MEMWB;
      end
    end
  end

`ifdef LOAD_FWD_EN
`else
  logic w_unused_isload;
  assign w_unused_isload = i_mem_isload;
`endif

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: EX/MEM/WB shadow pipeline, operand forward selects, one-cycle load-use stall.
// Outputs are combinational from shadow regs + ID inputs; shadow advances 1 cycle. STALL holds IF/ID (LOAD_FWD_EN removes it).
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = SH_REG_W,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             ID_VALID,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [REG_W-1:0] ID_RD,
  input  logic             ID_REGWRITE,
  input  logic             ID_ISLOAD,
  input  logic             ID_ISJUMP,
  input  logic             FLUSH,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             ISJUMP_A,
  output logic             ISJUMP_B,
  output logic             STALL,
  output logic [CNT_W-1:0] STALL_CNT
);

  shadow_t r_ex;
  shadow_t r_mem;
  shadow_t r_wb;
  shadow_t w_id;
  logic    w_stall;

  always_comb begin
    w_id          = SHADOW_BUBBLE;
    w_id.vld      = ID_VALID & ~w_stall & ~FLUSH;
    w_id.rs1      = ID_RS1;
    w_id.rs2      = ID_RS2;
    w_id.use1     = ID_USE_RS1;
    w_id.use2     = ID_USE_RS2;
    w_id.rd       = ID_RD;
    w_id.regwrite = ID_REGWRITE;
    w_id.isload   = ID_ISLOAD;
    w_id.isjump   = ID_ISJUMP;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_ex  <= SHADOW_BUBBLE;
      r_mem <= SHADOW_BUBBLE;
      r_wb  <= SHADOW_BUBBLE;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id;
    end
  end

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .i_rs           (r_ex.rs1),
    .i_use          (r_ex.use1),
    .i_ex_vld       (r_ex.vld),
    .i_mem_vld      (r_mem.vld),
    .i_mem_regwrite (r_mem.regwrite),
    .i_mem_isload   (r_mem.isload),
    .i_mem_isjump   (r_mem.isjump),
    .i_mem_rd       (r_mem.rd),
    .i_wb_vld       (r_wb.vld),
    .i_wb_regwrite  (r_wb.regwrite),
    .i_wb_rd        (r_wb.rd),
    .o_fwd          (FWD_A),
    .o_isjump       (ISJUMP_A)
  );

  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .i_rs           (r_ex.rs2),
    .i_use          (r_ex.use2),
    .i_ex_vld       (r_ex.vld),
    .i_mem_vld      (r_mem.vld),
    .i_mem_regwrite (r_mem.regwrite),
    .i_mem_isload   (r_mem.isload),
    .i_mem_isjump   (r_mem.isjump),
    .i_mem_rd       (r_mem.rd),
    .i_wb_vld       (r_wb.vld),
    .i_wb_regwrite  (r_wb.regwrite),
    .i_wb_rd        (r_wb.rd),
    .o_fwd          (FWD_B),
    .o_isjump       (ISJUMP_B)
  );

`ifdef LOAD_FWD_EN
  assign w_stall   = 1'b0;
  assign STALL_CNT = '0;
`else
  hz_state_t        r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;

  assign w_load_use = r_ex.vld & r_ex.isload & (r_ex.rd != '0) & ID_VALID &
                      ((ID_USE_RS1 & (ID_RS1 == r_ex.rd)) |
                       (ID_USE_RS2 & (ID_RS2 == r_ex.rd)));

  // The BUBBLE state masks the detector so each load costs at most one stall cycle.
  assign w_stall = (r_state == ST_RUN) & w_load_use & ~FLUSH;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      if (FLUSH) begin
        r_state <= ST_RUN;
      end else if (r_state == ST_RUN) begin
        if (w_load_use) r_state <= ST_BUBBLE;
      end else begin
        r_state <= ST_RUN;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign STALL_CNT = r_stall_cnt;
`endif

  assign STALL = w_stall;

  logic w_unused_shadow;
  assign w_unused_shadow = ^{r_ex, r_mem, r_wb};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed test-plan steps then random instruction streams against a history-based model.
module tb_fwd_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        ID_VALID;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD;
  logic        ID_USE_RS1, ID_USE_RS2;
  logic        ID_REGWRITE, ID_ISLOAD, ID_ISJUMP;
  logic        FLUSH;
  logic [1:0]  FWD_A, FWD_B;
  logic        ISJUMP_A, ISJUMP_B, STALL;
  logic [31:0] STALL_CNT;

  always #5 CLK = ~CLK;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .ID_VALID(ID_VALID),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .ID_RD(ID_RD), .ID_REGWRITE(ID_REGWRITE), .ID_ISLOAD(ID_ISLOAD), .ID_ISJUMP(ID_ISJUMP),
    .FLUSH(FLUSH), .FWD_A(FWD_A), .FWD_B(FWD_B), .ISJUMP_A(ISJUMP_A), .ISJUMP_B(ISJUMP_B),
    .STALL(STALL), .STALL_CNT(STALL_CNT)
  );

`ifdef LOAD_FWD_EN
  localparam bit LFE = 1'b1;
`else
  localparam bit LFE = 1'b0;
`endif

  typedef struct {
    bit v;
    int rs1, rs2;
    bit u1, u2;
    int rd;
    bit rw, ld, jp;
  } ent_t;

  // hist[0] = instruction now in EX, hist[1] = MEM, hist[2] = WB
  ent_t            hist [3];
  bit              m_prev_stall;
  longint unsigned m_cnt;
  int              n_chk = 0;
  int              n_pass = 0;

  function automatic ent_t bubble();
    ent_t e;
    e = '{v: 1'b0, rs1: 0, rs2: 0, u1: 1'b0, u2: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0, jp: 1'b0};
    return e;
  endfunction

  function automatic int exp_fwd(int rs, bit u);
    if (!hist[0].v || !u || rs == 0) return 0;
    if (hist[1].v && hist[1].rw && hist[1].rd == rs) return (LFE && hist[1].ld) ? 3 : 1;
    if (hist[2].v && hist[2].rw && hist[2].rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit exp_jmp(int rs, bit u);
    return (exp_fwd(rs, u) == 1) && hist[1].jp;
  endfunction

  function automatic bit exp_stall();
    bit dep;
    if (LFE || FLUSH || m_prev_stall) return 1'b0;
    dep = (ID_USE_RS1 && int'(ID_RS1) == hist[0].rd) || (ID_USE_RS2 && int'(ID_RS2) == hist[0].rd);
    return hist[0].v && hist[0].ld && hist[0].rd != 0 && ID_VALID && dep;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit jp);
    ID_VALID = v; ID_RS1 = rs1[4:0]; ID_RS2 = rs2[4:0];
    ID_USE_RS1 = u1; ID_USE_RS2 = u2; ID_RD = rd[4:0];
    ID_REGWRITE = rw; ID_ISLOAD = ld; ID_ISJUMP = jp;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs against the model mid-cycle, then advance the model on the clock edge.
  task automatic step();
    bit   s;
    ent_t e;
    @(negedge CLK);
    chk("fwd_a", FWD_A, exp_fwd(hist[0].rs1, hist[0].u1));
    chk("fwd_b", FWD_B, exp_fwd(hist[0].rs2, hist[0].u2));
    chk("isjump_a", ISJUMP_A, exp_jmp(hist[0].rs1, hist[0].u1));
    chk("isjump_b", ISJUMP_B, exp_jmp(hist[0].rs2, hist[0].u2));
    s = exp_stall();
    chk("stall", STALL, s);
    chk("stall_cnt", STALL_CNT, m_cnt);
    e = '{v: ID_VALID, rs1: int'(ID_RS1), rs2: int'(ID_RS2), u1: ID_USE_RS1, u2: ID_USE_RS2,
          rd: int'(ID_RD), rw: ID_REGWRITE, ld: ID_ISLOAD, jp: ID_ISJUMP};
    @(posedge CLK);
    if (!RSTn) begin
      for (int i = 0; i < 3; i++) hist[i] = bubble();
      m_prev_stall = 1'b0;
      m_cnt = 0;
    end else begin
      if (s && m_cnt != 64'hFFFF_FFFF) m_cnt++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (e.v && !s && !FLUSH) ? e : bubble();
      m_prev_stall = s;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = bubble();
    m_prev_stall = 1'b0;
    m_cnt = 0;
    RSTn = 1'b0;
    FLUSH = 1'b0;
    nop();
    #1;
    step();
    step();
    RSTn = 1'b1;
    #1;
    chk("rst_fwd_a", FWD_A, 0);
    chk("rst_stall", STALL, 0);
    chk("rst_cnt", STALL_CNT, 0);

    // add x5,x1,x2 ; add x6,x5,x1 back to back
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 0); step();
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); step();
    nop(); #1;
    chk("b2b_fwd_a", FWD_A, 1);
    chk("b2b_isjump_a", ISJUMP_A, 0);
    chk("b2b_fwd_b", FWD_B, 0);
    step(); step(); step();

    // one-instruction gap
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 0); step();
    nop(); step();
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); step();
    nop(); #1;
    chk("gap_fwd_a", FWD_A, 2);
    step(); step(); step();

    // jal x1 ; add x2,x1,x1
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 1); step();
    set_id(1, 1, 1, 1, 1, 2, 1, 0, 0); step();
    nop(); #1;
    chk("jal_fwd_a", FWD_A, 1);
    chk("jal_fwd_b", FWD_B, 1);
    chk("jal_isjump_a", ISJUMP_A, 1);
    chk("jal_isjump_b", ISJUMP_B, 1);
    step(); step(); step();

    // write x0 then read x0
    set_id(1, 3, 4, 1, 1, 0, 1, 0, 0); step();
    set_id(1, 0, 0, 1, 1, 3, 1, 0, 0); step();
    nop(); #1;
    chk("x0_fwd_a", FWD_A, 0);
    chk("x0_fwd_b", FWD_B, 0);
    step(); step(); step();

    // lw x7 ; add x8,x7,x7
    set_id(1, 2, 0, 1, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("lu_stall", STALL, LFE ? 0 : 1);
    step();
`ifdef LOAD_FWD_EN
    nop(); #1;
    chk("lu_fwd_a_dmem", FWD_A, 3);
    chk("lu_fwd_b_dmem", FWD_B, 3);
    chk("lu_stall_off", STALL, 0);
    chk("lu_cnt", STALL_CNT, 0);
`else
    #1;
    chk("lu_bubble_stall", STALL, 0);
    chk("lu_bubble_fwd_a", FWD_A, 0);
    step();
    nop(); #1;
    chk("lu_fwd_a_wb", FWD_A, 2);
    chk("lu_fwd_b_wb", FWD_B, 2);
    chk("lu_cnt", STALL_CNT, 1);
`endif
    step(); step(); step();

    // load-use with FLUSH in the same cycle
    set_id(1, 0, 0, 0, 0, 9, 1, 1, 0); step();
    set_id(1, 9, 0, 1, 0, 10, 1, 0, 0);
    FLUSH = 1'b1; #1;
    chk("flush_stall", STALL, 0);
    step();
    FLUSH = 1'b0;
    nop(); #1;
    chk("flush_fwd_a", FWD_A, 0);
    chk("flush_cnt", STALL_CNT, LFE ? 0 : 1);
    step(); step();

    // reset during the stall cycle
    set_id(1, 2, 0, 1, 0, 7, 1, 1, 0); step();
    set_id(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk("rs_stall", STALL, LFE ? 0 : 1);
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    nop(); #1;
    chk("rs_fwd_a", FWD_A, 0);
    chk("rs_fwd_b", FWD_B, 0);
    chk("rs_isjump", {ISJUMP_A, ISJUMP_B}, 0);
    chk("rs_stall_after", STALL, 0);
    chk("rs_cnt", STALL_CNT, 0);
    step();

    // random streams over a small register window to provoke many hazards
    for (int n = 0; n < 600; n++) begin
      RSTn  = ($urandom_range(0, 99) != 0);
      FLUSH = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
      step();
    end
    RSTn = 1'b1;
    FLUSH = 1'b0;
    nop();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
